// File: rtl/cpu_step_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_step_ctrl
//   Single-step / free-run clock-enable generator for a small CPU, with a
//   PC breakpoint. The CPU advances one instruction per cpu_en pulse.
//
// Parameters
//   PC_W   : width of the PC compared against the breakpoint address
//   DIV_W  : width of the run-rate divider
//   CNT_W  : width of the issued-step counter
//
// Ports
//   CLK       in   system clock, rising edge
//   RST       in   synchronous active-low reset
//   step_req  in   one-cycle pulse: issue one CPU step
//   run_req   in   one-cycle pulse: toggle free-run / pause
//   div_val   in   run period minus 1, in CLK cycles
//   bp_en     in   breakpoint enable
//   bp_addr   in   breakpoint PC
//   pc_in     in   current CPU PC
//   cpu_en    out  registered one-cycle CPU clock-enable pulse
//   running   out  high while free-running
//   halted    out  high while stopped on a breakpoint
//   step_cnt  out  number of cpu_en pulses issued (wraps)
// -----------------------------------------------------------------------------
module cpu_step_ctrl #(
   parameter int PC_W  = 5,
   parameter int DIV_W = 24,
   parameter int CNT_W = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             step_req,
   input  logic             run_req,
   input  logic [DIV_W-1:0] div_val,
   input  logic             bp_en,
   input  logic [PC_W-1:0]  bp_addr,
   input  logic [PC_W-1:0]  pc_in,
   output logic             cpu_en,
   output logic             running,
   output logic             halted,
   output logic [CNT_W-1:0] step_cnt
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_STEP = 2'd1,
      S_RUN  = 2'd2,
      S_HALT = 2'd3
   } state_t;

   state_t           r_state;
   logic [DIV_W-1:0] r_div_cnt;
   logic             r_skip_bp;
   logic             r_cpu_en;
   logic             r_running;
   logic             r_halted;
   logic [CNT_W-1:0] r_step_cnt;

   logic             w_tick;
   logic             w_bp_hit;

   // >= rather than == so that lowering div_val below the current count
   // fires on the next cycle instead of letting the counter run away.
   assign w_tick   = (r_div_cnt >= div_val);
   // skip_bp lets the CPU step off the instruction it halted on.
   assign w_bp_hit = bp_en && (pc_in == bp_addr) && !r_skip_bp;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_state    <= S_IDLE;
         r_div_cnt  <= '0;
         r_skip_bp  <= 1'b0;
         r_cpu_en   <= 1'b0;
         r_running  <= 1'b0;
         r_halted   <= 1'b0;
         r_step_cnt <= '0;
      end else begin
         // cpu_en is a one-cycle pulse unless re-asserted below
         r_cpu_en <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (run_req) begin
                  r_state   <= S_RUN;
                  r_div_cnt <= '0;
                  r_running <= 1'b1;
               end else if (step_req) begin
                  r_state    <= S_STEP;
                  r_cpu_en   <= 1'b1;
                  r_step_cnt <= r_step_cnt + 1'b1;
               end
            end

            // The pulse is already on the output; inputs are not looked at.
            S_STEP: begin
               r_state <= S_IDLE;
            end

            S_RUN: begin
               if (run_req) begin
                  // pause wins over any tick in the same cycle
                  r_state   <= S_IDLE;
                  r_div_cnt <= '0;
                  r_skip_bp <= 1'b0;
                  r_running <= 1'b0;
               end else if (w_tick) begin
                  r_div_cnt <= '0;
                  if (w_bp_hit) begin
                     r_state   <= S_HALT;
                     r_running <= 1'b0;
                     r_halted  <= 1'b1;
                  end else begin
                     r_cpu_en   <= 1'b1;
                     r_step_cnt <= r_step_cnt + 1'b1;
                     r_skip_bp  <= 1'b0;
                  end
               end else begin
                  r_div_cnt <= r_div_cnt + 1'b1;
               end
            end

            S_HALT: begin
               if (run_req) begin
                  r_state   <= S_RUN;
                  r_div_cnt <= '0;
                  r_skip_bp <= 1'b1;
                  r_running <= 1'b1;
                  r_halted  <= 1'b0;
               end else if (step_req) begin
                  r_state    <= S_STEP;
                  r_cpu_en   <= 1'b1;
                  r_step_cnt <= r_step_cnt + 1'b1;
                  r_halted   <= 1'b0;
               end
            end

            default: begin
               r_state   <= S_IDLE;
               r_running <= 1'b0;
               r_halted  <= 1'b0;
            end
         endcase
      end
   end

   assign cpu_en   = r_cpu_en;
   assign running  = r_running;
   assign halted   = r_halted;
   assign step_cnt = r_step_cnt;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpu_step_ctrl
//   Scoreboard bench for cpu_step_ctrl. Inputs for cycle c are driven on the
//   falling edge inside cycle c; the reference model then predicts the
//   outputs of cycle c+1 and queues them. A monitor pops one prediction
//   after every rising edge and compares it with the DUT outputs.
//   The run-rate model keeps a timestamp of the last divider clear and
//   compares elapsed cycles against div_val.
// -----------------------------------------------------------------------------
module tb_cpu_step_ctrl;

   localparam int PC_W  = 5;
   localparam int DIV_W = 24;
   localparam int CNT_W = 8;

   logic             CLK;
   logic             RST;
   logic             step_req;
   logic             run_req;
   logic [DIV_W-1:0] div_val;
   logic             bp_en;
   logic [PC_W-1:0]  bp_addr;
   logic [PC_W-1:0]  pc_in;
   logic             cpu_en;
   logic             running;
   logic             halted;
   logic [CNT_W-1:0] step_cnt;

   cpu_step_ctrl #(.PC_W(PC_W), .DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .step_req (step_req),
      .run_req  (run_req),
      .div_val  (div_val),
      .bp_en    (bp_en),
      .bp_addr  (bp_addr),
      .pc_in    (pc_in),
      .cpu_en   (cpu_en),
      .running  (running),
      .halted   (halted),
      .step_cnt (step_cnt)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct packed {
      logic             en;
      logic             run;
      logic             halt;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   pulse_log[$];
   int   checks = 0;
   int   errors = 0;

   // stimulus settings copied onto the pins at the falling edge
   logic [DIV_W-1:0] s_div     = '0;
   logic             s_bp_en   = 1'b0;
   logic [PC_W-1:0]  s_bp_addr = '0;
   logic [PC_W-1:0]  s_pc      = '0;
   bit               pc_track  = 1'b0;
   int               pc_base   = 0;
   int               last_cyc  = 0;

   // reference model state
   typedef enum int {MD_IDLE, MD_STEP, MD_RUN, MD_HALT} mode_t;
   mode_t            m_mode   = MD_IDLE;
   bit               m_skip   = 1'b0;
   longint           t_clr    = 0;
   logic [CNT_W-1:0] m_cnt    = '0;
   int               m_pulses = 0;

   task automatic chk(input string nm, input longint act, input longint want);
      checks++;
      if (act != want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, want);
      end
   endtask

   // Predict outputs of cycle cyc+1 from the inputs on the pins in cycle cyc.
   task automatic model_step();
      exp_t e;
      bit   en;
      en = 1'b0;
      if (!RST) begin
         m_mode = MD_IDLE;
         m_skip = 1'b0;
         m_cnt  = '0;
      end else begin
         case (m_mode)
            MD_IDLE: begin
               if (run_req) begin
                  m_mode = MD_RUN;
                  t_clr  = cyc + 1;
               end else if (step_req) begin
                  m_mode = MD_STEP;
                  en     = 1'b1;
               end
            end
            MD_STEP: m_mode = MD_IDLE;
            MD_RUN: begin
               if (run_req) begin
                  m_mode = MD_IDLE;
                  m_skip = 1'b0;
               end else if ((longint'(cyc) - t_clr) >= longint'(div_val)) begin
                  t_clr = cyc + 1;
                  if (bp_en && (pc_in == bp_addr) && !m_skip) begin
                     m_mode = MD_HALT;
                  end else begin
                     en     = 1'b1;
                     m_skip = 1'b0;
                  end
               end
            end
            MD_HALT: begin
               if (run_req) begin
                  m_mode = MD_RUN;
                  m_skip = 1'b1;
                  t_clr  = cyc + 1;
               end else if (step_req) begin
                  m_mode = MD_STEP;
                  en     = 1'b1;
               end
            end
            default: m_mode = MD_IDLE;
         endcase
      end
      if (en) begin
         m_cnt    = m_cnt + 1'b1;
         m_pulses = m_pulses + 1;
      end
      e.en   = en;
      e.run  = (m_mode == MD_RUN);
      e.halt = (m_mode == MD_HALT);
      e.cnt  = m_cnt;
      exp_q.push_back(e);
   endtask

   // One cycle of stimulus. With pc_track set, the CPU PC counts the
   // pulses issued so far, including a pulse visible in this cycle.
   task automatic drive(input bit rst, input bit run, input bit step);
      @(negedge CLK);
      RST      = rst;
      run_req  = run;
      step_req = step;
      div_val  = s_div;
      bp_en    = s_bp_en;
      bp_addr  = s_bp_addr;
      pc_in    = pc_track ? PC_W'(m_pulses - pc_base) : s_pc;
      last_cyc = cyc;
      model_step();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0);
   endtask

   task automatic settle();
      @(posedge CLK);
      #2;
   endtask

   // monitor: one prediction per cycle
   initial begin
      exp_t e;
      exp_t act;
      forever begin
         @(posedge CLK);
         #1;
         if (cpu_en === 1'b1) pulse_log.push_back(cyc);
         if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            act = {cpu_en, running, halted, step_cnt};
            checks++;
            if (act !== e) begin
               errors++;
               $display("FAIL cyc%0d outputs: got en=%b run=%b halt=%b cnt=%0d expected en=%b run=%b halt=%b cnt=%0d",
                        cyc, act.en, act.run, act.halt, act.cnt, e.en, e.run, e.halt, e.cnt);
            end
         end
      end
   end

   initial begin
      int s;
      int r;
      RST = 1'b0; run_req = 1'b0; step_req = 1'b0; div_val = '0;
      bp_en = 1'b0; bp_addr = '0; pc_in = '0;

      // reset, then a single step
      repeat (3) drive(1'b0, 1'b0, 1'b0);
      idle(5);
      settle();
      pulse_log.delete();
      drive(1'b1, 1'b0, 1'b1);
      s = last_cyc;
      idle(3);
      settle();
      chk("step_pulses", pulse_log.size(), 1);
      if (pulse_log.size() == 1) chk("step_pulse_cycle", pulse_log[0] - s, 1);
      chk("step_cnt_after_step", step_cnt, 1);
      chk("running_after_step", running, 0);

      // run rate with div_val=3, paused after the third pulse
      s_div = DIV_W'(3);
      pulse_log.delete();
      drive(1'b1, 1'b1, 1'b0);
      r = last_cyc;
      idle(13);
      drive(1'b1, 1'b1, 1'b0);
      idle(10);
      settle();
      chk("run_pulses", pulse_log.size(), 3);
      if (pulse_log.size() == 3) begin
         chk("run_pulse0", pulse_log[0] - r, 5);
         chk("run_pulse1", pulse_log[1] - r, 9);
         chk("run_pulse2", pulse_log[2] - r, 13);
      end
      chk("running_after_pause", running, 0);

      // breakpoint at PC 4, div_val=0
      s_div = '0; s_bp_en = 1'b1; s_bp_addr = 5'h04;
      pc_track = 1'b1; pc_base = m_pulses;
      pulse_log.delete();
      drive(1'b1, 1'b1, 1'b0);
      idle(10);
      settle();
      chk("bp_pulses_before_halt", pulse_log.size(), 4);
      chk("bp_halted", halted, 1);
      pulse_log.delete();
      drive(1'b1, 1'b1, 1'b0);
      idle(5);
      settle();
      chk("bp_resume_pulses", pulse_log.size(), 5);
      chk("bp_resume_running", running, 1);
      drive(1'b1, 1'b1, 1'b0);
      pc_track = 1'b0; s_bp_en = 1'b0;

      // run_req and step_req together in IDLE
      s_div = DIV_W'(2);
      idle(2);
      settle();
      pulse_log.delete();
      drive(1'b1, 1'b1, 1'b1);
      idle(1);
      settle();
      chk("conflict_no_step", pulse_log.size(), 0);
      chk("conflict_running", running, 1);
      drive(1'b1, 1'b1, 1'b0);

      // step out of HALT
      s_bp_en = 1'b1; s_bp_addr = 5'h07; s_pc = 5'h07;
      drive(1'b1, 1'b1, 1'b0);
      idle(6);
      settle();
      chk("halt_reached", halted, 1);
      pulse_log.delete();
      drive(1'b1, 1'b0, 1'b1);
      idle(3);
      settle();
      chk("halt_step_pulses", pulse_log.size(), 1);
      chk("halt_step_halted", halted, 0);
      s_bp_en = 1'b0;

      // step counter wrap after 256 steps
      drive(1'b0, 1'b0, 1'b0);
      pulse_log.delete();
      for (int i = 0; i < 256; i++) begin
         drive(1'b1, 1'b0, 1'b1);
         drive(1'b1, 1'b0, 1'b0);
      end
      settle();
      chk("wrap_pulses", pulse_log.size(), 256);
      chk("wrap_step_cnt", step_cnt, 0);

      // reset on the cycle before a scheduled run pulse
      s_div = DIV_W'(3);
      pulse_log.delete();
      drive(1'b1, 1'b1, 1'b0);
      idle(3);
      drive(1'b0, 1'b0, 1'b0);
      idle(4);
      settle();
      chk("reset_cancels_pulse", pulse_log.size(), 0);
      chk("reset_outputs", {cpu_en, running, halted, step_cnt}, 0);

      // randomized traffic, PC following the issued pulses
      pc_track = 1'b1; pc_base = 0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 15) == 0) s_div = DIV_W'($urandom_range(0, 6));
         if ($urandom_range(0, 31) == 0) begin
            s_bp_en   = 1'($urandom_range(0, 1));
            s_bp_addr = PC_W'($urandom_range(0, 31));
         end
         drive($urandom_range(0, 199) != 0, $urandom_range(0, 19) == 0,
               $urandom_range(0, 7) == 0);
      end
      idle(3);
      settle();
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cpu_step_ctrl.md
CPU_STEP_CTRL -- requirements
Module: cpu_step_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  PC_W   5    PC width compared for breakpoint
  DIV_W  24   run-rate divider width
  CNT_W  8    issued-step counter width
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  CLK       in   1      single system clock, all logic rising-edge
  RST       in   1      synchronous active-low reset
  step_req  in   1      one-cycle pulse (debounced key): request one CPU step
  run_req   in   1      one-cycle pulse: toggle free-run / pause
  div_val   in   DIV_W  run period minus 1, in CLK cycles
  bp_en     in   1      breakpoint enable
  bp_addr   in   PC_W   breakpoint PC
  pc_in     in   PC_W   current CPU PC
  cpu_en    out  1      registered one-cycle CPU clock-enable pulse
  running   out  1      high while in RUN
  halted    out  1      high while in HALT (breakpoint hit)
  step_cnt  out  CNT_W  count of cpu_en pulses issued
REQ-003 The block SHALL use one clock (CLK); reset SHALL be synchronous and active-low (RST).

Function
REQ-004 FSM states SHALL be IDLE, STEP, RUN, HALT; running = (state==RUN); halted = (state==HALT).
REQ-005 IDLE: run_req -> RUN (div counter cleared); else step_req -> STEP; else stay.
REQ-006 STEP SHALL last exactly one cycle, assert cpu_en in that cycle, then return to IDLE; step_req at cycle n -> cpu_en high at cycle n+1 only.
REQ-007 RUN: div counter increments each cycle; when counter >= div_val ("tick"), counter clears to 0 and cpu_en is high the following cycle.
REQ-008 Run timing: run_req at cycle n -> first cpu_en at n+2+div_val, then every div_val+1 cycles; div_val=0 -> cpu_en every cycle from n+2.
REQ-009 div_val SHALL be sampled every cycle; a decrease below the current count fires on the next cycle (>= compare); no wrap of the counter.
REQ-010 RUN: run_req -> IDLE, counter cleared, any tick in that cycle suppressed; step_req ignored in RUN.
REQ-011 Breakpoint: on a tick with bp_en=1, pc_in==bp_addr and skip_bp=0, cpu_en SHALL NOT pulse and state -> HALT.
REQ-012 HALT: run_req -> RUN with skip_bp=1 and counter cleared; else step_req -> STEP; else stay.
REQ-013 skip_bp SHALL clear on the first tick after being set (that tick issues cpu_en normally), or on leaving RUN.
REQ-014 Simultaneous run_req and step_req: run_req wins, step_req dropped.
REQ-015 step_cnt SHALL increment by 1 per cpu_en pulse, wrapping 2^CNT_W-1 -> 0.
REQ-016 cpu_en SHALL never be high on two consecutive cycles except in RUN with div_val=0.

Reset
REQ-017 RST=0 at a rising edge SHALL force state IDLE, cpu_en 0, running 0, halted 0, div counter 0, skip_bp 0, step_cnt 0.
REQ-018 Reset mid-RUN or mid-STEP SHALL cancel any pending cpu_en; no pulse in the cycle after reset.
REQ-019 Inputs SHALL be ignored while RST=0; first action is taken on the first edge with RST=1.

Verification
REQ-020 Step: reset, step_req at cycle 10 -> cpu_en high at cycle 11 only, step_cnt=1, state IDLE.
REQ-021 Run rate: div_val=3, run_req at cycle 0 -> cpu_en at 5, 9, 13; run_req at 14 -> no further pulses, running=0.
REQ-022 Breakpoint: bp_en=1, bp_addr=5'h04, div_val=0, pc_in advanced by 1 per cpu_en from 0 -> four pulses, then halted=1 with pc_in=4 and no fifth pulse; run_req -> next pulse issued despite pc_in=4, then running continues.
REQ-023 Conflicts: step_req and run_req same cycle in IDLE -> RUN entered, no STEP pulse; step_req in HALT -> one pulse, halted=0, state IDLE.
REQ-024 Wrap/reset: CNT_W=8, 256 steps -> step_cnt=0; RST=0 on the cycle before a scheduled pulse -> no pulse, all outputs 0.
